// File: rtl/key_pkg.sv
// Shared encodings and width helpers for the key event scheduler.
// Combinational only; no latency or backpressure of its own.
package key_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS = 2'b00,
    EVT_REL   = 2'b01,
    EVT_LONG  = 2'b10,
    EVT_REP   = 2'b11
  } evt_type_e;

  // Index width for a key bank; a single key still needs one bit.
  function automatic int key_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Valid/ready event port from the key scheduler to the UI/menu FSM.
// Producer holds key/type stable while valid is high and ready is low.
interface key_event_ctrl_if
  import key_pkg::*;
#(
  parameter int KEY_NUM = 4
);
  localparam int KEY_IDX_W = key_idx_w(KEY_NUM);

  logic                 evt_valid;
  logic                 evt_ready;
  logic [KEY_IDX_W-1:0] evt_key;
  evt_type_e            evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_chan.sv
// One key: 2-flop sync, tick-based debounce, hold/repeat timer, four pending flags.
// Flags are set on commit/timer edges and cleared by the arbiter; set wins over clear.
module key_chan
  import key_pkg::*;
#(
  parameter int DEB_MS  = 20,
  parameter int LONG_MS = 1000,
  parameter int REPT_MS = 200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_raw,
  input  logic tick,
  input  logic clr_press,
  input  logic clr_rel,
  input  logic clr_long,
  input  logic clr_rep,
  output logic key_state,
  output logic pend_press,
  output logic pend_rel,
  output logic pend_long,
  output logic pend_rep,
  output logic ovf
);
  localparam int DEB_W  = cnt_w(DEB_MS);
  localparam int HOLD_W = cnt_w(LONG_MS + 1);
  localparam int SUB_W  = cnt_w(REPT_MS);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MS - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(REPT_MS - 1);

  logic              sync0_q, sync0_d, sync1_q, sync1_d;
  logic              state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              press_q, press_d, rel_q, rel_d, long_q, long_d, rep_q, rep_d;
  logic              synced, press_cmt, rel_cmt;
  logic              set_press, set_rel, set_long, set_rep;

  always_comb begin
    sync0_d   = key_raw;
    sync1_d   = sync0_q;
    synced    = ~sync1_q;
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    sub_d     = sub_q;
    press_cmt = 1'b0;
    rel_cmt   = 1'b0;
    set_press = 1'b0;
    set_rel   = 1'b0;
    set_long  = 1'b0;
    set_rep   = 1'b0;

    if (synced == state_q) begin
      deb_d = '0;
    end else if (tick) begin
      if (deb_q == DEB_LAST) begin
        state_d   = synced;
        deb_d     = '0;
        press_cmt = synced;
        rel_cmt   = ~synced;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end

    // Commit edges take priority over the hold timer in the same tick.
    if (press_cmt) begin
      hold_d    = '0;
      sub_d     = '0;
      set_press = 1'b1;
    end else if (rel_cmt) begin
      hold_d  = '0;
      sub_d   = '0;
      set_rel = 1'b1;
    end else if (state_q && tick) begin
      if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_PRE) begin
          set_long = 1'b1;
          sub_d    = '0;
        end
      end else if (sub_q == SUB_LAST) begin
        set_rep = 1'b1;
        sub_d   = '0;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    press_d = set_press | (press_q & ~clr_press);
    rel_d   = set_rel   | (rel_q   & ~clr_rel);
    long_d  = set_long  | (long_q  & ~clr_long);
    rep_d   = set_rep   | (rep_q   & ~clr_rep & ~rel_cmt);
    ovf     = (set_press & press_q & ~clr_press) | (set_rel & rel_q & ~clr_rel) |
              (set_long  & long_q  & ~clr_long)  | (set_rep & rep_q & ~clr_rep);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      state_q <= 1'b0;
      deb_q   <= '0;
      hold_q  <= '0;
      sub_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      sub_q   <= sub_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign key_state  = state_q;
  assign pend_press = press_q;
  assign pend_rel   = rel_q;
  assign pend_long  = long_q;
  assign pend_rep   = rep_q;
endmodule

// File: rtl/key_event_ctrl.sv
// Key bank scheduler: shared ms prescaler, per-key channels, round-robin event arbiter.
// Event appears one cycle after its flag is set; output holds under !evt_ready, 1 event/cycle when ready.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int KEY_NUM  = 4,
  parameter int TICK_DIV = 50_000,
  parameter int DEB_MS   = 20,
  parameter int LONG_MS  = 1000,
  parameter int REPT_MS  = 200
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  key_event_ctrl_if.master   evt,
  output logic [KEY_NUM-1:0] key_state,
  output logic               evt_ovf
);
  localparam int KEY_IDX_W = key_idx_w(KEY_NUM);
  localparam int TICK_W    = cnt_w(TICK_DIV);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [KEY_IDX_W-1:0] KEY_LAST  = KEY_IDX_W'(KEY_NUM - 1);

  logic [TICK_W-1:0]    presc_q, presc_d;
  logic                 tick;
  logic [KEY_NUM-1:0]   pend_press, pend_rel, pend_long, pend_rep, chan_ovf, cand;
  logic [KEY_NUM-1:0]   clr_press, clr_rel, clr_long, clr_rep;
  logic [KEY_IDX_W-1:0] rr_q, rr_d, gnt;
  logic                 found;
  int                   scan_idx;
  logic                 evt_valid_q, evt_valid_d, evt_ovf_q, evt_ovf_d;
  logic [KEY_IDX_W-1:0] evt_key_q, evt_key_d;
  evt_type_e            evt_type_q, evt_type_d;

  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_chan #(
      .DEB_MS (DEB_MS),
      .LONG_MS(LONG_MS),
      .REPT_MS(REPT_MS)
    ) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_raw   (key_in[i]),
      .tick      (tick),
      .clr_press (clr_press[i]),
      .clr_rel   (clr_rel[i]),
      .clr_long  (clr_long[i]),
      .clr_rep   (clr_rep[i]),
      .key_state (key_state[i]),
      .pend_press(pend_press[i]),
      .pend_rel  (pend_rel[i]),
      .pend_long (pend_long[i]),
      .pend_rep  (pend_rep[i]),
      .ovf       (chan_ovf[i])
    );
  end

  always_comb begin
    cand        = pend_press | pend_rel | pend_long | pend_rep;
    found       = 1'b0;
    gnt         = '0;
    scan_idx    = 0;
    clr_press   = '0;
    clr_rel     = '0;
    clr_long    = '0;
    clr_rep     = '0;
    rr_d        = rr_q;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    evt_ovf_d   = |chan_ovf;

    for (int k = 0; k < KEY_NUM; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= KEY_NUM) scan_idx = scan_idx - KEY_NUM;
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        gnt   = KEY_IDX_W'(scan_idx);
      end
    end

    // Press before release within a key keeps the per-key event order causal.
    if (!evt_valid_q || evt.evt_ready) begin
      if (found) begin
        evt_valid_d = 1'b1;
        evt_key_d   = gnt;
        rr_d        = (gnt == KEY_LAST) ? '0 : gnt + 1'b1;
        if (pend_press[gnt]) begin
          evt_type_d     = EVT_PRESS;
          clr_press[gnt] = 1'b1;
        end else if (pend_long[gnt]) begin
          evt_type_d    = EVT_LONG;
          clr_long[gnt] = 1'b1;
        end else if (pend_rep[gnt]) begin
          evt_type_d   = EVT_REP;
          clr_rep[gnt] = 1'b1;
        end else begin
          evt_type_d   = EVT_REL;
          clr_rel[gnt] = 1'b1;
        end
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q     <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= EVT_PRESS;
      evt_ovf_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_key   = evt_key_q;
  assign evt.evt_type  = evt_type_q;
  assign evt_ovf       = evt_ovf_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a short timebase (4 cycles/tick).
// Handshakes are logged with cycle stamps and compared against hand-derived sequences.
module tb_key_event_ctrl;
  import key_pkg::*;

  localparam int KN = 4;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [KN-1:0] key_in    = '1;
  logic [KN-1:0] key_state;
  logic          evt_ovf;

  key_event_ctrl_if #(.KEY_NUM(KN)) evt_if ();

  key_event_ctrl #(
    .KEY_NUM (KN),
    .TICK_DIV(4),
    .DEB_MS  (3),
    .LONG_MS (10),
    .REPT_MS (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .evt      (evt_if),
    .key_state(key_state),
    .evt_ovf  (evt_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int cyc;
    int key;
    int typ;
  } ev_t;

  ev_t evq[$];
  int  cyc     = 0;
  int  ovf_cnt = 0;
  int  checks  = 0;
  int  errors  = 0;

  always @(negedge sys_clk) begin
    if (sys_rst_n && evt_if.evt_valid && evt_if.evt_ready)
      evq.push_back('{cyc, int'(evt_if.evt_key), int'(evt_if.evt_type)});
    if (evt_ovf) ovf_cnt++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int i, input int key, input int typ);
    if (i < evq.size()) begin
      chk({tag, "_key"}, evq[i].key, key);
      chk({tag, "_type"}, evq[i].typ, typ);
    end else begin
      chk({tag, "_missing"}, evq.size(), i + 1);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n        = 1'b0;
    key_in           = '1;
    evt_if.evt_ready = 1'b0;
    step(3);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_evq(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, evq.size() >= n, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, c0, lat, bad, n, ovf0, k;
    evt_if.evt_ready = 1'b0;
    step(2);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_key", evt_if.evt_key, 0);
    chk("rst_type", evt_if.evt_type, 0);
    chk("rst_ovf", evt_ovf, 0);
    chk("rst_state", key_state, 0);

    // Clean press of key 2, held 20 cycles
    do_reset();
    evt_if.evt_ready = 1'b1;
    base      = evq.size();
    c0        = cyc;
    key_in[2] = 1'b0;
    wait_evq("t1_wait", base + 1, 40);
    chk_ev("t1_press", base, 2, EVT_PRESS);
    if (evq.size() > base) begin
      lat = evq[base].cyc - c0;
      chk("t1_lat", lat, clampi(lat, 12, 16));
    end
    chk("t1_state", key_state, 4'b0100);
    while (cyc - c0 < 20) step(1);
    key_in[2] = 1'b1;
    wait_evq("t1_rel_wait", base + 2, 40);
    chk_ev("t1_rel", base + 1, 2, EVT_REL);
    chk("t1_state_off", key_state, 0);

    // Key 0 bounces every 3 cycles, then settles low
    do_reset();
    evt_if.evt_ready = 1'b1;
    base = evq.size();
    for (int seg = 0; seg < 10; seg++) begin
      key_in[0] = seg[0];
      step(3);
    end
    chk("t2_no_bounce_evt", evq.size() - base, 0);
    c0        = cyc;
    key_in[0] = 1'b0;
    wait_evq("t2_wait", base + 1, 40);
    chk_ev("t2_press", base, 0, EVT_PRESS);
    if (evq.size() > base) begin
      lat = evq[base].cyc - c0;
      chk("t2_lat", lat, clampi(lat, 12, 16));
    end

    // Key 1 held 80 ticks: press, long, 17 repeats, release
    do_reset();
    evt_if.evt_ready = 1'b1;
    base      = evq.size();
    key_in[1] = 1'b0;
    step(320);
    key_in[1] = 1'b1;
    step(100);
    n = evq.size() - base;
    chk("t3_count", n, 20);
    chk_ev("t3_press", base, 1, EVT_PRESS);
    chk_ev("t3_long", base + 1, 1, EVT_LONG);
    if (n >= 2) chk("t3_long_dt", evq[base + 1].cyc - evq[base].cyc, 40);
    for (int i = base + 2; i < evq.size() - 1; i++) begin
      chk("t3_rep_type", evq[i].typ, EVT_REP);
      chk("t3_rep_dt", evq[i].cyc - evq[i - 1].cyc, 16);
    end
    if (n >= 3) begin
      chk_ev("t3_rel", evq.size() - 1, 1, EVT_REL);
      chk("t3_rel_dt", evq[evq.size() - 1].cyc - evq[base].cyc, 320);
    end

    // Keys 0 and 3 together with the consumer stalled
    do_reset();
    base      = evq.size();
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    k = 0;
    while (!evt_if.evt_valid && k < 40) begin
      step(1);
      k++;
    end
    chk("t4_valid", evt_if.evt_valid, 1);
    bad = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!(evt_if.evt_valid && evt_if.evt_key == 0 && evt_if.evt_type == EVT_PRESS)) bad++;
    end
    chk("t4_hold_stable", bad, 0);
    @(posedge sys_clk);
    #1;
    evt_if.evt_ready = 1'b1;
    step(4);
    chk_ev("t4_first", base, 0, EVT_PRESS);
    chk_ev("t4_second", base + 1, 3, EVT_PRESS);
    if (evq.size() >= base + 2) chk("t4_second_dt", evq[base + 1].cyc - evq[base].cyc, 1);
    chk_ev("t4_rr_wrap", base + 2, 0, EVT_LONG);

    // Merge overflow while the output register is occupied
    do_reset();
    base      = evq.size();
    ovf0      = ovf_cnt;
    key_in[0] = 1'b0;
    step(20);
    chk("t5_busy", evt_if.evt_valid, 1);
    key_in[0] = 1'b1;
    key_in[1] = 1'b0;
    step(20);
    key_in[1] = 1'b1;
    step(20);
    key_in[1] = 1'b0;
    step(20);
    chk("t5_ovf_once", ovf_cnt - ovf0, 1);
    chk("t5_hold_key", evt_if.evt_key, 0);
    evt_if.evt_ready = 1'b1;
    step(6);
    chk_ev("t5_e0", base, 0, EVT_PRESS);
    chk_ev("t5_e1", base + 1, 1, EVT_PRESS);
    chk_ev("t5_e2", base + 2, 0, EVT_REL);
    chk_ev("t5_e3", base + 3, 1, EVT_REL);

    // Reset mid-operation discards pending events
    do_reset();
    key_in[0] = 1'b0;
    key_in[1] = 1'b0;
    step(30);
    chk("t6_pre_valid", evt_if.evt_valid, 1);
    chk("t6_pre_state", key_state, 4'b0011);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", evt_if.evt_valid, 0);
    chk("t6_rst_state", key_state, 0);
    key_in = '1;
    step(3);
    sys_rst_n        = 1'b1;
    base             = evq.size();
    evt_if.evt_ready = 1'b1;
    step(80);
    chk("t6_no_stale", evq.size() - base, 0);
    chk("t6_idle_valid", evt_if.evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
